// File: rtl/branch_outcome_tracker.sv
// In-flight branch tracker: records predictor directions at IF and scores them
// against the actual outcome when the same branch resolves in WB (FIFO order).
module branch_outcome_tracker #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_isbranch,
  input  logic [15:0]              if_pc,
  input  logic                     lc_pred_taken,
  input  logic                     gl_pred_taken,
  input  logic                     wbisbranch,
  input  logic [15:0]              wb_pcplus2,
  input  logic                     wb_taken,
  input  logic                     flush,
  output logic                     lc_pred_correct,
  output logic                     gl_pred_correct,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_overflow,
  output logic                     err_underflow,
  output logic                     err_pc_mismatch
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   r_pc [DEPTH];
  logic          r_lc [DEPTH];
  logic          r_gl [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_err_overflow;
  logic          r_err_underflow;
  logic          r_err_pc_mismatch;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_head_nxt;
  logic [AW-1:0] w_tail_nxt;
  logic [15:0]   w_exp_pc;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = wbisbranch & ~w_empty;
  // A pop frees the head slot this edge, so a full FIFO may still accept a push.
  assign w_push     = if_isbranch & ~flush & (~w_full | w_pop);
  assign w_head_nxt = r_head + AW'(1);
  assign w_tail_nxt = r_tail + AW'(1);
  assign w_exp_pc   = wb_pcplus2 - 16'h0002;

  assign lc_pred_correct = w_pop & (r_lc[r_head] == wb_taken);
  assign gl_pred_correct = w_pop & (r_gl[r_head] == wb_taken);
  assign full            = w_full;
  assign empty           = w_empty;
  assign count           = r_count;
  assign err_overflow    = r_err_overflow;
  assign err_underflow   = r_err_underflow;
  assign err_pc_mismatch = r_err_pc_mismatch;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_tail] <= if_pc;
      r_lc[r_tail] <= lc_pred_taken;
      r_gl[r_tail] <= gl_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_err_overflow    <= 1'b0;
      r_err_underflow   <= 1'b0;
      r_err_pc_mismatch <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head <= w_head_nxt;
      end
      if (flush) begin
        // Collapse the queue onto the post-pop head; younger entries are wrong-path.
        r_tail  <= w_pop ? w_head_nxt : r_head;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= w_tail_nxt;
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
      if (if_isbranch & ~flush & w_full & ~w_pop) begin
        r_err_overflow <= 1'b1;
      end
      if (wbisbranch & w_empty) begin
        r_err_underflow <= 1'b1;
      end
      if (w_pop && (r_pc[r_head] != w_exp_pc)) begin
        r_err_pc_mismatch <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Directed bench for branch_outcome_tracker (DEPTH=8) with hand-computed expectations.
module tb_branch_outcome_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_isbranch;
  logic [15:0] if_pc;
  logic        lc_pred_taken;
  logic        gl_pred_taken;
  logic        wbisbranch;
  logic [15:0] wb_pcplus2;
  logic        wb_taken;
  logic        flush;
  logic        lc_pred_correct;
  logic        gl_pred_correct;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_pc_mismatch;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  branch_outcome_tracker #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_isbranch    (if_isbranch),
    .if_pc          (if_pc),
    .lc_pred_taken  (lc_pred_taken),
    .gl_pred_taken  (gl_pred_taken),
    .wbisbranch     (wbisbranch),
    .wb_pcplus2     (wb_pcplus2),
    .wb_taken       (wb_taken),
    .flush          (flush),
    .lc_pred_correct(lc_pred_correct),
    .gl_pred_correct(gl_pred_correct),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .err_overflow   (err_overflow),
    .err_underflow  (err_underflow),
    .err_pc_mismatch(err_pc_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if_isbranch   = 1'b0;
    if_pc         = 16'h0000;
    lc_pred_taken = 1'b0;
    gl_pred_taken = 1'b0;
    wbisbranch    = 1'b0;
    wb_pcplus2    = 16'h0000;
    wb_taken      = 1'b0;
    flush         = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [15:0] pc, input logic lc, input logic gl);
    if_isbranch   = 1'b1;
    if_pc         = pc;
    lc_pred_taken = lc;
    gl_pred_taken = gl;
  endtask

  task automatic pop(input logic [15:0] pcp2, input logic tk);
    wbisbranch = 1'b1;
    wb_pcplus2 = pcp2;
    wb_taken   = tk;
  endtask

  task automatic chk_errs(input string tag, input logic ov, input logic un, input logic pm);
    chk({tag, ".ovf"}, 32'(err_overflow), 32'(ov));
    chk({tag, ".unf"}, 32'(err_underflow), 32'(un));
    chk({tag, ".pcm"}, 32'(err_pc_mismatch), 32'(pm));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.lc", 32'(lc_pred_correct), 32'd0);
    chk("rst.gl", 32'(gl_pred_correct), 32'd0);
    chk_errs("rst", 1'b0, 1'b0, 1'b0);

    // Single branch
    push(16'h0100, 1'b1, 1'b0);
    tick();
    chk("single.count1", 32'(count), 32'd1);
    pop(16'h0102, 1'b1);
    #1;
    chk("single.lc", 32'(lc_pred_correct), 32'd1);
    chk("single.gl", 32'(gl_pred_correct), 32'd0);
    tick();
    chk("single.count0", 32'(count), 32'd0);
    chk_errs("single", 1'b0, 1'b0, 1'b0);

    // Fill to full: entry i has pc 0x1000+2i, lc=i[0], gl=i[1]
    for (int i = 0; i < 8; i++) begin
      push(16'h1000 + 16'(2 * i), i[0], i[1]);
      tick();
    end
    chk("fill.count", 32'(count), 32'd8);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.empty", 32'(empty), 32'd0);

    push(16'hDEAD, 1'b1, 1'b1);
    tick();
    chk("ovf.count", 32'(count), 32'd8);
    chk_errs("ovf", 1'b1, 1'b0, 1'b0);

    // Push+pop while full: entry0 (lc0 gl0) vs taken=0 -> both correct
    push(16'h2000, 1'b1, 1'b1);
    pop(16'h1002, 1'b0);
    #1;
    chk("fullpp.lc", 32'(lc_pred_correct), 32'd1);
    chk("fullpp.gl", 32'(gl_pred_correct), 32'd1);
    tick();
    chk("fullpp.count", 32'(count), 32'd8);
    chk("fullpp.full", 32'(full), 32'd1);

    for (int i = 1; i < 8; i++) begin
      pop(16'h1002 + 16'(2 * i), 1'b1);
      #1;
      chk($sformatf("drain%0d.lc", i), 32'(lc_pred_correct), 32'(i[0]));
      chk($sformatf("drain%0d.gl", i), 32'(gl_pred_correct), 32'(i[1]));
      tick();
    end
    chk("drain.count", 32'(count), 32'd1);
    pop(16'h2002, 1'b1);
    #1;
    chk("wrap.lc", 32'(lc_pred_correct), 32'd1);
    chk("wrap.gl", 32'(gl_pred_correct), 32'd1);
    tick();
    chk("wrap.count", 32'(count), 32'd0);
    chk("wrap.empty", 32'(empty), 32'd1);
    chk_errs("wrap", 1'b1, 1'b0, 1'b0);

    // Underflow
    pop(16'h0002, 1'b0);
    #1;
    chk("unf.lc", 32'(lc_pred_correct), 32'd0);
    chk("unf.gl", 32'(gl_pred_correct), 32'd0);
    tick();
    chk("unf.count", 32'(count), 32'd0);
    chk_errs("unf", 1'b1, 1'b1, 1'b0);

    // PC mismatch: pc 0x0200 vs pcplus2 0x0300
    push(16'h0200, 1'b0, 1'b1);
    tick();
    pop(16'h0300, 1'b0);
    #1;
    chk("pcm.lc", 32'(lc_pred_correct), 32'd1);
    chk("pcm.gl", 32'(gl_pred_correct), 32'd0);
    tick();
    chk("pcm.count", 32'(count), 32'd0);
    chk_errs("pcm", 1'b1, 1'b1, 1'b1);

    // Flush with concurrent pop and push
    for (int i = 0; i < 3; i++) begin
      push(16'h3000 + 16'(2 * i), 1'b1, 1'b1);
      tick();
    end
    chk("flush.pre", 32'(count), 32'd3);
    pop(16'h3002, 1'b0);
    push(16'h4000, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush.lc", 32'(lc_pred_correct), 32'd0);
    chk("flush.gl", 32'(gl_pred_correct), 32'd0);
    tick();
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.empty", 32'(empty), 32'd1);
    push(16'h5000, 1'b0, 1'b1);
    tick();
    chk("postflush.count", 32'(count), 32'd1);
    pop(16'h5002, 1'b1);
    #1;
    chk("postflush.lc", 32'(lc_pred_correct), 32'd0);
    chk("postflush.gl", 32'(gl_pred_correct), 32'd1);
    tick();
    chk("postflush.count0", 32'(count), 32'd0);

    // Reset mid-operation with 5 entries
    for (int i = 0; i < 5; i++) begin
      push(16'h6000 + 16'(2 * i), 1'b1, 1'b0);
      tick();
    end
    chk("midrst.pre", 32'(count), 32'd5);
    rst_n = 1'b0;
    push(16'h7000, 1'b1, 1'b1);
    pop(16'h6002, 1'b1);
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.empty", 32'(empty), 32'd1);
    chk("midrst.full", 32'(full), 32'd0);
    chk_errs("midrst", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
